// File: rtl/pe_stream_fetch.sv
`default_nettype none
// ============================================================================
// Module      : pe_stream_fetch
// Description : Streaming operand fetch engine for one PE. Accepts a single
//               stream request (layer, filter k, filter/input enables), reads
//               the filter and activation header words from the PE-local
//               operand memory, then streams the filter words followed by the
//               activation words through a small skid FIFO to the multiplier
//               array under valid/ready back-pressure.
// Ports       : clk, rst               - clock, async active-high reset
//               req_*                  - request handshake and fields
//               mem_rd_en/addr/data    - operand memory read port (1-cycle latency)
//               out_valid/ready/data   - operand stream to the multiplier array
//               out_is_filter/out_last - word tag, final word of the request
//               done                   - one-cycle completion pulse
// Revision    : 1.0 - initial release
// ============================================================================
module pe_stream_fetch #(
   parameter int DATA_W       = 32,
   parameter int ADDR_W       = 16,
   parameter int NUM_LAYER    = 8,
   parameter int MAX_K        = 16,
   parameter int FLT_HDR_BASE = 0,
   parameter int ACT_HDR_BASE = 128,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         req_valid,
   output logic                         req_ready,
   input  logic                         req_filter_en,
   input  logic                         req_input_en,
   input  logic [$clog2(MAX_K)-1:0]     req_filter_k,
   input  logic [$clog2(NUM_LAYER)-1:0] req_layer,
   output logic                         mem_rd_en,
   output logic [ADDR_W-1:0]            mem_rd_addr,
   input  logic [DATA_W-1:0]            mem_rd_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [DATA_W-1:0]            out_data,
   output logic                         out_is_filter,
   output logic                         out_last,
   output logic                         done
);

   localparam int C_PTR_W = $clog2(FIFO_DEPTH);
   localparam int C_CNT_W = C_PTR_W + 1;
   localparam int C_K_W   = $clog2(MAX_K);
   localparam int C_L_W   = $clog2(NUM_LAYER);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_F_HDR  = 3'd1,
      S_F_WAIT = 3'd2,
      S_F_STRM = 3'd3,
      S_A_HDR  = 3'd4,
      S_A_WAIT = 3'd5,
      S_A_STRM = 3'd6,
      S_DRAIN  = 3'd7
   } state_t;

   // ---------------------------------------------------------------- state
   state_t               r_state;
   state_t               w_state_n;
   logic [C_L_W-1:0]     r_layer;
   logic [C_K_W-1:0]     r_k;
   logic                 r_inp_en;
   logic [ADDR_W-1:0]    r_addr;
   logic [15:0]          r_remain;
   logic                 r_done;

   // One read can be in flight at a time (1-cycle memory latency).
   logic                 r_inf_valid;
   logic                 r_inf_flt;
   logic                 r_inf_last;
   logic                 r_inf_flt_fin;

   logic [DATA_W-1:0]    r_fifo_data [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] r_fifo_flt;
   logic [FIFO_DEPTH-1:0] r_fifo_last;
   logic [C_PTR_W-1:0]   r_wptr;
   logic [C_PTR_W-1:0]   r_rptr;
   logic [C_CNT_W-1:0]   r_count;

   // Final filter word whose "last" status depends on a not-yet-read
   // activation count; resolved when the activation header returns.
   logic                 r_flt_pend;
   logic [C_PTR_W-1:0]   r_flt_idx;

   // ---------------------------------------------------------------- wires
   logic [15:0]          w_hdr_cnt;
   logic [ADDR_W-1:0]    w_hdr_start;
   logic [ADDR_W-1:0]    w_flt_hdr_addr;
   logic [ADDR_W-1:0]    w_act_hdr_addr;
   logic                 w_accept;
   logic                 w_push;
   logic                 w_pop;
   logic [C_CNT_W-1:0]   w_occ;
   logic                 w_credit;
   logic                 w_issue;
   logic                 w_drain_ok;
   logic                 w_fix_last;
   logic                 w_fix_head;

   assign w_hdr_cnt      = mem_rd_data[31:16];
   assign w_hdr_start    = ADDR_W'(mem_rd_data[15:0]);
   assign w_flt_hdr_addr = ADDR_W'(FLT_HDR_BASE) + ADDR_W'(r_layer) * ADDR_W'(MAX_K) + ADDR_W'(r_k);
   assign w_act_hdr_addr = ADDR_W'(ACT_HDR_BASE) + ADDR_W'(r_layer);

   assign req_ready  = (r_state == S_IDLE) && !rst;
   assign w_accept   = req_valid && req_ready;
   assign w_push     = r_inf_valid;
   assign out_valid  = (r_count != '0);
   assign w_pop      = out_valid && out_ready;

   // Credit counts the in-flight read so a full FIFO can never overflow.
   assign w_occ      = r_count + C_CNT_W'(r_inf_valid);
   assign w_credit   = (w_occ < C_CNT_W'(FIFO_DEPTH));

   assign w_drain_ok = !r_inf_valid &&
                       ((r_count == '0) || ((r_count == C_CNT_W'(1)) && w_pop));

   // Zero activation count: the last filter word becomes the request's last.
   assign w_fix_last = (r_state == S_A_WAIT) && (w_hdr_cnt == 16'd0) && r_flt_pend;
   assign w_fix_head = w_fix_last && (r_rptr == r_flt_idx);

   assign out_data      = out_valid ? r_fifo_data[r_rptr] : '0;
   assign out_is_filter = out_valid && r_fifo_flt[r_rptr];
   assign out_last      = out_valid && (r_fifo_last[r_rptr] || w_fix_head);
   assign done          = r_done;

   // ---------------------------------------------------------------- FSM comb
   always_comb begin
      w_state_n   = r_state;
      mem_rd_en   = 1'b0;
      mem_rd_addr = '0;
      w_issue     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (req_filter_en)     w_state_n = S_F_HDR;
               else if (req_input_en) w_state_n = S_A_HDR;
               else                   w_state_n = S_DRAIN;
            end
         end
         S_F_HDR: begin
            mem_rd_en   = 1'b1;
            mem_rd_addr = w_flt_hdr_addr;
            w_state_n   = S_F_WAIT;
         end
         S_F_WAIT: begin
            if (w_hdr_cnt == 16'd0) w_state_n = r_inp_en ? S_A_HDR : S_DRAIN;
            else                    w_state_n = S_F_STRM;
         end
         S_F_STRM: begin
            if (w_credit) begin
               mem_rd_en   = 1'b1;
               mem_rd_addr = r_addr;
               w_issue     = 1'b1;
               if (r_remain == 16'd1) w_state_n = r_inp_en ? S_A_HDR : S_DRAIN;
            end
         end
         S_A_HDR: begin
            mem_rd_en   = 1'b1;
            mem_rd_addr = w_act_hdr_addr;
            w_state_n   = S_A_WAIT;
         end
         S_A_WAIT: begin
            if (w_hdr_cnt == 16'd0) w_state_n = S_DRAIN;
            else                    w_state_n = S_A_STRM;
         end
         S_A_STRM: begin
            if (w_credit) begin
               mem_rd_en   = 1'b1;
               mem_rd_addr = r_addr;
               w_issue     = 1'b1;
               if (r_remain == 16'd1) w_state_n = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (w_drain_ok) w_state_n = S_IDLE;
         end
         default: w_state_n = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------- control
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_layer       <= '0;
         r_k           <= '0;
         r_inp_en      <= 1'b0;
         r_addr        <= '0;
         r_remain      <= '0;
         r_done        <= 1'b0;
         r_inf_valid   <= 1'b0;
         r_inf_flt     <= 1'b0;
         r_inf_last    <= 1'b0;
         r_inf_flt_fin <= 1'b0;
      end else begin
         r_state <= w_state_n;
         r_done  <= (r_state == S_DRAIN) && w_drain_ok;
         if (w_accept) begin
            r_layer  <= req_layer;
            r_k      <= req_filter_k;
            r_inp_en <= req_input_en;
         end
         if ((r_state == S_F_WAIT) || (r_state == S_A_WAIT)) begin
            r_addr   <= w_hdr_start;
            r_remain <= w_hdr_cnt;
         end else if (w_issue) begin
            r_addr   <= r_addr + ADDR_W'(1);
            r_remain <= r_remain - 16'd1;
         end
         r_inf_valid   <= w_issue;
         r_inf_flt     <= (r_state == S_F_STRM);
         // Filter-final word is known last only when no activation phase follows.
         r_inf_last    <= w_issue && (r_remain == 16'd1) &&
                          ((r_state == S_A_STRM) || !r_inp_en);
         r_inf_flt_fin <= w_issue && (r_remain == 16'd1) &&
                          (r_state == S_F_STRM) && r_inp_en;
      end
   end

   // ---------------------------------------------------------------- FIFO
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) r_fifo_data[i] <= '0;
         r_fifo_flt  <= '0;
         r_fifo_last <= '0;
         r_wptr      <= '0;
         r_rptr      <= '0;
         r_count     <= '0;
         r_flt_pend  <= 1'b0;
         r_flt_idx   <= '0;
      end else begin
         if (w_push) begin
            r_fifo_data[r_wptr] <= mem_rd_data;
            r_fifo_flt[r_wptr]  <= r_inf_flt;
            r_fifo_last[r_wptr] <= r_inf_last;
            r_wptr              <= r_wptr + C_PTR_W'(1);
            if (r_inf_flt_fin) begin
               r_flt_pend <= 1'b1;
               r_flt_idx  <= r_wptr;
            end
         end
         // No push can occur in A_WAIT, so this never collides with a write.
         if (w_fix_last) r_fifo_last[r_flt_idx] <= 1'b1;
         if (w_pop) r_rptr <= r_rptr + C_PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + C_CNT_W'(1);
            2'b01:   r_count <= r_count - C_CNT_W'(1);
            default: r_count <= r_count;
         endcase
         if (w_accept) r_flt_pend <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pe_stream_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_pe_stream_fetch
// Description : Directed self-checking bench for pe_stream_fetch. Models the
//               1-cycle-latency operand memory, logs every read and every
//               output handshake, and compares against hand-built sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pe_stream_fetch;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_filter_en = 1'b0;
   logic        req_input_en = 1'b0;
   logic [3:0]  req_filter_k = '0;
   logic [2:0]  req_layer = '0;
   logic        mem_rd_en;
   logic [15:0] mem_rd_addr;
   logic [31:0] mem_rd_data = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_data;
   logic        out_is_filter;
   logic        out_last;
   logic        done;

   pe_stream_fetch dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_filter_en (req_filter_en),
      .req_input_en  (req_input_en),
      .req_filter_k  (req_filter_k),
      .req_layer     (req_layer),
      .mem_rd_en     (mem_rd_en),
      .mem_rd_addr   (mem_rd_addr),
      .mem_rd_data   (mem_rd_data),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_data      (out_data),
      .out_is_filter (out_is_filter),
      .out_last      (out_last),
      .done          (done)
   );

   always #5 clk = ~clk;

   // Operand memory: data valid the cycle after the read strobe.
   logic [31:0] mem [0:65535];
   always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // out_ready driver: 0 = always 1, 1 = pattern 1,0,0,1, 2 = always 0
   int rdy_mode = 0;
   int pidx = 0;
   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0: out_ready = 1'b1;
         1: begin
            out_ready = (pidx == 0) || (pidx == 3);
            pidx = (pidx + 1) % 4;
         end
         default: out_ready = 1'b0;
      endcase
   end

   // Monitor (samples on the falling edge)
   int          cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [63:0] got_q[$];
   logic [15:0] rd_q[$];
   logic [63:0] exp_q[$];
   int          acc_cyc = -1;
   int          first_valid_cyc = -1;
   int          done_cnt = 0;
   int          done_cyc = -1;
   int          stab_err = 0;
   int          sreads = 0;
   int          pops = 0;
   int          max_out = 0;
   logic        stall_prev = 1'b0;
   logic [63:0] stall_word = '0;

   always @(negedge clk) begin
      if (!rst) begin
         if (mem_rd_en) begin
            rd_q.push_back(mem_rd_addr);
            if (mem_rd_addr >= 16'h0200) sreads++;
         end
         if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
         if (stall_prev && (!out_valid || {30'd0, out_last, out_is_filter, out_data} != stall_word))
            stab_err++;
         stall_prev = out_valid && !out_ready;
         stall_word = {30'd0, out_last, out_is_filter, out_data};
         if (out_valid && out_ready) begin
            got_q.push_back({30'd0, out_last, out_is_filter, out_data});
            pops++;
         end
         if (sreads - pops > max_out) max_out = sreads - pops;
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (req_valid && req_ready) acc_cyc = cyc;
      end else begin
         stall_prev = 1'b0;
      end
   end

   function automatic logic [31:0] wv(input int a);
      return 32'hD000_0000 | a;
   endfunction

   function automatic logic [63:0] ew(input bit last, input bit flt, input int a);
      return {30'd0, last, flt, wv(a)};
   endfunction

   task automatic clear_logs();
      got_q.delete();
      rd_q.delete();
      exp_q.delete();
      first_valid_cyc = -1;
      acc_cyc = -1;
      done_cnt = 0;
      done_cyc = -1;
      stab_err = 0;
      sreads = 0;
      pops = 0;
      max_out = 0;
   endtask

   task automatic run_req(input string tag, input int layer, input int k, input bit fe, input bit ie);
      int t;
      @(posedge clk); #1;
      req_valid     = 1'b1;
      req_layer     = layer[2:0];
      req_filter_k  = k[3:0];
      req_filter_en = fe;
      req_input_en  = ie;
      t = 0;
      while (acc_cyc < 0 && t < 20) begin
         @(posedge clk);
         t++;
      end
      #1 req_valid = 1'b0;
      chk({tag, "_accepted"}, acc_cyc >= 0, 1);
      t = 0;
      while (done_cnt == 0 && t < 400) begin
         @(posedge clk);
         t++;
      end
      repeat (4) @(posedge clk);
      chk({tag, "_done_once"}, done_cnt, 1);
   endtask

   task automatic cmp_stream(input string tag);
      chk({tag, "_nwords"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         chk($sformatf("%s_word%0d", tag, i), got_q[i], exp_q[i]);
   endtask

   task automatic exp_basic();
      exp_q.push_back(ew(0, 1, 'h200));
      exp_q.push_back(ew(0, 1, 'h201));
      exp_q.push_back(ew(0, 1, 'h202));
      exp_q.push_back(ew(0, 0, 'h300));
      exp_q.push_back(ew(1, 0, 'h301));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = wv(i);
      mem[18]  = {16'd3, 16'h0200};   // layer1 k2 filter header
      mem[129] = {16'd2, 16'h0300};   // layer1 activation header
      mem[32]  = {16'd0, 16'h0400};   // layer2 k0 filter header (empty)
      mem[130] = {16'd1, 16'h0500};   // layer2 activation header
      mem[53]  = {16'd2, 16'hFFFF};   // layer3 k5 filter header (wraps)
      mem[132] = {16'd6, 16'h0600};   // layer4 activation header
      mem[81]  = {16'd1, 16'h0700};   // layer5 k1 filter header
      mem[133] = {16'd0, 16'h0000};   // layer5 activation header (empty)

      // Reset values
      #3;
      chk("rst_req_ready", req_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_rd_en", mem_rd_en, 0);
      chk("rst_rd_addr", mem_rd_addr, 0);
      chk("rst_outputs", {out_data, out_is_filter, out_last, done}, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #1 chk("post_rst_req_ready", req_ready, 1);

      // Layer1 k2, both phases, out_ready held high
      rdy_mode = 0;
      clear_logs();
      exp_basic();
      run_req("basic", 1, 2, 1, 1);
      cmp_stream("basic");
      chk("basic_first_valid_lat", first_valid_cyc - (acc_cyc + 1), 4);
      chk("basic_max_outstanding", max_out <= 4, 1);

      // Same request, out_ready toggling 1,0,0,1
      rdy_mode = 1;
      clear_logs();
      exp_basic();
      run_req("stall", 1, 2, 1, 1);
      cmp_stream("stall");
      chk("stall_stable", stab_err, 0);
      chk("stall_max_outstanding", max_out <= 4, 1);

      // Filter count 0, one activation word
      rdy_mode = 0;
      clear_logs();
      exp_q.push_back(ew(1, 0, 'h500));
      run_req("fzero", 2, 0, 1, 1);
      cmp_stream("fzero");

      // No enables: no reads, no output, done the cycle after DRAIN
      clear_logs();
      run_req("empty", 0, 0, 0, 0);
      chk("empty_no_reads", rd_q.size(), 0);
      chk("empty_no_valid", first_valid_cyc, -1);
      chk("empty_done_lat", done_cyc - (acc_cyc + 1), 1);

      // Address wrap 0xFFFF -> 0x0000, filter only
      clear_logs();
      exp_q.push_back(ew(0, 1, 'hFFFF));
      exp_q.push_back(ew(1, 1, 'h0000));
      run_req("wrap", 3, 5, 1, 0);
      cmp_stream("wrap");
      chk("wrap_nreads", rd_q.size(), 3);
      if (rd_q.size() == 3) begin
         chk("wrap_rd0", rd_q[0], 16'd53);
         chk("wrap_rd1", rd_q[1], 16'hFFFF);
         chk("wrap_rd2", rd_q[2], 16'h0000);
      end

      // Activation count 0: last filter word carries out_last
      clear_logs();
      exp_q.push_back(ew(1, 1, 'h700));
      run_req("azero", 5, 1, 1, 0 + 1);
      cmp_stream("azero");

      // Reset during activation streaming with two words buffered
      rdy_mode = 2;
      clear_logs();
      @(posedge clk); #1;
      req_valid = 1'b1; req_layer = 3'd4; req_filter_k = 4'd0;
      req_filter_en = 1'b0; req_input_en = 1'b1;
      @(posedge clk); #1;          // accept edge
      req_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("midrst_pre_valid", out_valid, 1);
      chk("midrst_pre_word", {out_is_filter, out_data}, {1'b0, wv('h600)});
      rst = 1'b1;
      #1;
      chk("midrst_valid", out_valid, 0);
      chk("midrst_ready", req_ready, 0);
      chk("midrst_rd_en", mem_rd_en, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      rdy_mode = 0;
      clear_logs();
      exp_basic();
      run_req("after_rst", 1, 2, 1, 1);
      cmp_stream("after_rst");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
